shift_add_mult_ctrl: RTL and testbench



---
 rtl/shift_add_mult_ctrl_pkg.sv | 19 +
 rtl/shift_add_mult_ctrl_if.sv | 23 ++
 rtl/shift_add_mult_ctrl_add_shift_step.sv | 43 ++++
 rtl/shift_add_mult_ctrl.sv | 102 ++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the controller state encoding, default operand width and counter sizing helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Requester-side bundle for the multiplier: start/operands in, busy/done/product out.
// Latency: n/a (wiring only). Backpressure: start is only honoured while the controller is idle or done.
// The requester uses the master modport and the controller uses the slave modport.
interface shift_add_mult_ctrl_if #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_mult_ctrl_add_shift_step.sv
// One shift-add iteration: conditional ripple add of a into acc, then right shift of {carry,acc,mq}.
// Latency: combinational. Backpressure: none.
// The carry out of the add lands in the acc MSB after the shift, so no bit is ever lost.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module add_shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mq_nxt
);
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    assign addend   = mq[0] ? a : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        fa_cell u_fa (
            .x  (acc[i]),
            .y  (addend[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign acc_nxt = {carry[WIDTH], sum[WIDTH-1:1]};
    assign mq_nxt  = {sum[0], mq[WIDTH-1:1]};
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Iterative unsigned WIDTH x WIDTH multiplier controller; EARLY_TERM_EN enables early completion.
// Latency: WIDTH RUN cycles after the accepting edge (fewer with EARLY_TERM_EN); done pulses one cycle.
// Backpressure: start is ignored during RUN; a start seen in DONE is accepted back-to-back.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_mult_ctrl_if.slave  bus
);
    localparam int CNT_W = cnt_w(WIDTH);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mq_q, mq_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH-1:0]     step_acc;
    logic [WIDTH-1:0]     step_mq;
    logic [CNT_W-1:0]     cnt_dec;

    add_shift_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc_q),
        .mq      (mq_q),
        .a       (a_q),
        .acc_nxt (step_acc),
        .mq_nxt  (step_mq)
    );

    assign cnt_dec = cnt_q - CNT_W'(1);

`ifdef EARLY_TERM_EN
    // Low cnt_dec bits of the shifted mq are the multiplier bits still to be consumed.
    logic [WIDTH-1:0] rem_mask;
    assign rem_mask = (WIDTH'(1) << cnt_dec) - WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    acc_d   = '0;
                    mq_d    = bus.b;
                    cnt_d   = CNT_W'(WIDTH);
                end
            end
            RUN: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_dec;
`ifdef EARLY_TERM_EN
                // Remaining iterations would only add zero, i.e. a plain right shift.
                if ((step_mq & rem_mask) == '0) begin
                    state_d = DONE;
                    prod_d  = {step_acc, step_mq} >> cnt_dec;
                end
`else
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    prod_d  = {step_acc, step_mq};
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = prod_q;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: directed corners, back-to-back, abort and random operands.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_shift_add_mult_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    shift_add_mult_ctrl_if #(.WIDTH(W)) bus ();

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Number of RUN cycles the multiplier b should take.
    function automatic int exp_lat(input logic [W-1:0] m);
`ifdef EARLY_TERM_EN
        int l = 1;
        for (int i = 0; i < W; i++)
            if (m[i]) l = i + 1;
        return l;
`else
        return W;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge in RUN; returns on the negedge where done is seen (or after the bound).
    task automatic wait_done(output int cyc, output bit got, output bit ok);
        logic [63:0] p0;
        p0  = bus.product;
        cyc = 0;
        got = 1'b0;
        ok  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                got = 1'b1;
                if (bus.busy) ok = 1'b0;
                break;
            end
            if (!bus.busy || bus.product !== p0) ok = 1'b0;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_);
        int cyc;
        bit got, ok;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        wait_done(cyc, got, ok);
        check({tag, ".done"},    64'(got), 64'd1);
        check({tag, ".product"}, bus.product, 64'(ta) * 64'(tb_));
        check({tag, ".latency"}, 64'(cyc), 64'(exp_lat(tb_)));
        check({tag, ".flags"},   64'(ok), 64'd1);
        @(negedge clk);
        check({tag, ".pulse"},   64'({bus.done, bus.busy}), 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  got, ok, seen_done;
        int  abort_at;
        logic [W-1:0] ra, rb;

        // Reset held with start asserted: nothing may start.
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        repeat (3) @(negedge clk);
        check("reset.busy",    64'(bus.busy), 64'd0);
        check("reset.done",    64'(bus.done), 64'd0);
        check("reset.product", bus.product,   64'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset.idle", 64'({bus.busy, bus.done}), 64'd0);

        do_op("basic_6x7", 32'd6, 32'd7);
        do_op("max",       32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max.const", bus.product, 64'hFFFF_FFFE_0000_0001);
        do_op("zero_a",    32'd0, 32'd5);
        do_op("zero_b",    32'd5, 32'd0);
        do_op("one_b",     32'hDEAD_BEEF, 32'd1);
        do_op("msb_b",     32'd3, 32'h8000_0000);

        // Back-to-back with start held high; mid-RUN operand changes must be ignored.
        bus.start = 1'b1;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(negedge clk);
        bus.a = 32'd10;
        bus.b = 32'd10;
        wait_done(cyc, got, ok);
        check("b2b1.done",    64'(got), 64'd1);
        check("b2b1.product", bus.product, 64'd12);
        check("b2b1.latency", 64'(cyc), 64'(exp_lat(32'd4)));
        @(negedge clk);
        wait_done(cyc, got, ok);
        check("b2b2.done",    64'(got), 64'd1);
        check("b2b2.spacing", 64'(cyc + 1), 64'(exp_lat(32'd10) + 1));
        check("b2b2.product", bus.product, 64'd100);
        check("b2b2.flags",   64'(ok), 64'd1);
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b.idle", 64'({bus.busy, bus.done}), 64'd0);
        @(negedge clk);

        // Abort mid-RUN via reset.
        abort_at  = (exp_lat(32'd9) > 10) ? 10 : exp_lat(32'd9) - 1;
        seen_done = 1'b0;
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i < abort_at; i++) begin
            if (bus.done) seen_done = 1'b1;
            @(negedge clk);
        end
        check("abort.running", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort.no_done", 64'({seen_done, bus.done}), 64'd0);
        check("abort.idle",    64'(bus.busy), 64'd0);
        check("abort.product", bus.product, 64'd0);
        @(negedge clk);
        check("abort.stay_idle", 64'({bus.busy, bus.done}), 64'd0);
        do_op("after_abort", 32'd9, 32'd9);

        // Random operands; multiplier width varied to spread early-completion latencies.
        for (int n = 0; n < 1200; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) ra = '0;
            if ($urandom_range(0, 15) == 0) rb = '0;
            do_op("rand", ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
